// File: rtl/game_ctrl.sv
// game_ctrl: top-level game sequencer for a single-screen arcade game.
//
// Tracks the game state (TITLE, PLAY, DEAD, CLEAR) and detects the start of
// each video frame. Collisions seen during a frame are latched and acted on
// at the next frame start. Counts deaths, enforces a minimum dead time before
// restart, and pulses a sprite reset whenever play begins.
//
// Parameters:
//   DEAD_FRAMES  frames that must pass in DEAD before a restart is accepted (1..255)
//   RESTART_BIT  index into keys of the restart key
//
// Ports:
//   clk           system/pixel clock
//   rst           asynchronous active-high reset
//   col, row      current scan position; (0,0) marks the frame start
//   keys          key levels, already synchronised to clk (1 = pressed)
//   is_kid        kid sprite covers the current pixel
//   is_apple_any  some apple covers the current pixel
//   is_goal       goal region covers the current pixel
//   state         0 TITLE, 1 PLAY, 2 DEAD, 3 CLEAR
//   freeze        1 while sprite motion is halted
//   sprite_rst    one-cycle pulse that returns sprites to their start positions
//   frame_tick    one-cycle pulse following the (0,0) sample
//   death_count   saturating death counter, cleared only by rst
module game_ctrl #(
  parameter int unsigned DEAD_FRAMES = 30,
  parameter int unsigned RESTART_BIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] col,
  input  logic [9:0] row,
  input  logic [3:0] keys,
  input  logic       is_kid,
  input  logic       is_apple_any,
  input  logic       is_goal,
  output logic [1:0] state,
  output logic       freeze,
  output logic       sprite_rst,
  output logic       frame_tick,
  output logic [7:0] death_count
);

  typedef enum logic [1:0] {
    StTitle = 2'd0,
    StPlay  = 2'd1,
    StDead  = 2'd2,
    StClear = 2'd3
  } state_e;

  localparam logic [7:0] DeadMax    = DEAD_FRAMES[7:0];
  localparam logic [1:0] RestartSel = RESTART_BIT[1:0];

  state_e     state_q;
  logic [3:0] keys_q;
  logic       hit_flag_q;
  logic       goal_flag_q;
  logic [7:0] dead_cnt_q;
  logic [7:0] death_count_q;
  logic       freeze_q;
  logic       sprite_rst_q;
  logic       frame_tick_q;

  logic       frame_start;
  logic [3:0] press;
  logic       hit_now;
  logic       goal_now;

  always_comb begin
    frame_start = (col == 10'd0) && (row == 10'd0);
    press       = keys & ~keys_q;
    hit_now     = (state_q == StPlay) && is_kid && is_apple_any;
    goal_now    = (state_q == StPlay) && is_kid && is_goal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StTitle;
      keys_q        <= 4'd0;
      hit_flag_q    <= 1'b0;
      goal_flag_q   <= 1'b0;
      dead_cnt_q    <= 8'd0;
      death_count_q <= 8'd0;
      freeze_q      <= 1'b1;
      sprite_rst_q  <= 1'b0;
      frame_tick_q  <= 1'b0;
    end else begin
      keys_q       <= keys;
      frame_tick_q <= frame_start;
      sprite_rst_q <= 1'b0;

      // Flags restart each frame; a collision in the (0,0) cycle belongs to
      // the new frame, so it is loaded rather than dropped.
      if (frame_start) begin
        hit_flag_q  <= hit_now;
        goal_flag_q <= goal_now;
      end else begin
        hit_flag_q  <= hit_flag_q | hit_now;
        goal_flag_q <= goal_flag_q | goal_now;
      end

      case (state_q)
        StTitle: begin
          if (|press) begin
            state_q      <= StPlay;
            freeze_q     <= 1'b0;
            sprite_rst_q <= 1'b1;
            hit_flag_q   <= 1'b0;
            goal_flag_q  <= 1'b0;
          end
        end
        StPlay: begin
          // Decisions use the flags latched over the previous frame only.
          if (frame_start) begin
            if (hit_flag_q) begin
              state_q    <= StDead;
              freeze_q   <= 1'b1;
              dead_cnt_q <= 8'd0;
              if (death_count_q != 8'hff) begin
                death_count_q <= death_count_q + 8'd1;
              end
            end else if (goal_flag_q) begin
              state_q  <= StClear;
              freeze_q <= 1'b1;
            end
          end
        end
        StDead: begin
          if (press[RestartSel] && (dead_cnt_q == DeadMax)) begin
            state_q      <= StPlay;
            freeze_q     <= 1'b0;
            sprite_rst_q <= 1'b1;
            hit_flag_q   <= 1'b0;
            goal_flag_q  <= 1'b0;
          end else if (frame_start && (dead_cnt_q != DeadMax)) begin
            dead_cnt_q <= dead_cnt_q + 8'd1;
          end
        end
        StClear: begin
          if (|press) begin
            state_q <= StTitle;
          end
        end
        default: begin
          state_q <= StTitle;
        end
      endcase
    end
  end

  assign state       = state_q;
  assign freeze      = freeze_q;
  assign sprite_rst  = sprite_rst_q;
  assign frame_tick  = frame_tick_q;
  assign death_count = death_count_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus randomized stimulus, all
// outputs compared every cycle against a frame-level reference model.
module tb_game_ctrl;

  localparam int DF = 30;

  logic       clk;
  logic       rst;
  logic [9:0] col;
  logic [9:0] row;
  logic [3:0] keys;
  logic       is_kid;
  logic       is_apple_any;
  logic       is_goal;
  logic [1:0] state;
  logic       freeze;
  logic       sprite_rst;
  logic       frame_tick;
  logic [7:0] death_count;

  int total;
  int bad;

  // Reference model: 0 TITLE, 1 PLAY, 2 DEAD, 3 CLEAR
  int       m_state;
  int       m_deaths;
  int       m_dead_frames;
  bit       m_hit_seen;
  bit       m_goal_seen;
  bit       m_sprite;
  bit       m_tick;
  bit [3:0] m_prev_keys;

  game_ctrl #(
    .DEAD_FRAMES(DF),
    .RESTART_BIT(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .col          (col),
    .row          (row),
    .keys         (keys),
    .is_kid       (is_kid),
    .is_apple_any (is_apple_any),
    .is_goal      (is_goal),
    .state        (state),
    .freeze       (freeze),
    .sprite_rst   (sprite_rst),
    .frame_tick   (frame_tick),
    .death_count  (death_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state       = 0;
    m_deaths      = 0;
    m_dead_frames = 0;
    m_hit_seen    = 1'b0;
    m_goal_seen   = 1'b0;
    m_sprite      = 1'b0;
    m_tick        = 1'b0;
    m_prev_keys   = 4'd0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_edge();
    bit       new_frame;
    bit [3:0] pressed;
    bit       hit;
    bit       goal;
    int       next;
    if (rst) begin
      model_reset();
      return;
    end
    new_frame = (col == 0) && (row == 0);
    pressed   = keys & ~m_prev_keys;
    hit       = (m_state == 1) && is_kid && is_apple_any;
    goal      = (m_state == 1) && is_kid && is_goal;
    next      = m_state;
    m_sprite  = 1'b0;
    case (m_state)
      0: if (pressed != 0) begin next = 1; m_sprite = 1'b1; end
      1: if (new_frame && m_hit_seen) begin
           next = 2;
           m_dead_frames = 0;
           if (m_deaths < 255) m_deaths++;
         end else if (new_frame && m_goal_seen) begin
           next = 3;
         end
      2: if (pressed[3] && m_dead_frames == DF) begin
           next = 1; m_sprite = 1'b1;
         end else if (new_frame && m_dead_frames < DF) begin
           m_dead_frames++;
         end
      default: if (pressed != 0) next = 0;
    endcase
    if (next == 1 && m_state != 1) begin
      m_hit_seen  = 1'b0;
      m_goal_seen = 1'b0;
    end else if (new_frame) begin
      m_hit_seen  = hit;
      m_goal_seen = goal;
    end else begin
      m_hit_seen  = m_hit_seen | hit;
      m_goal_seen = m_goal_seen | goal;
    end
    m_tick      = new_frame;
    m_prev_keys = keys;
    m_state     = next;
  endtask

  task automatic compare_all();
    check_eq("state", {30'd0, state}, m_state);
    check_eq("freeze", {31'd0, freeze}, (m_state != 1) ? 1 : 0);
    check_eq("sprite_rst", {31'd0, sprite_rst}, {31'd0, m_sprite});
    check_eq("frame_tick", {31'd0, frame_tick}, {31'd0, m_tick});
    check_eq("death_count", {24'd0, death_count}, m_deaths);
  endtask

  // One clock: drive inputs, take the edge, compare 1 time unit later.
  task automatic cyc(input logic [9:0] c, input logic [9:0] r, input logic [3:0] k,
                     input logic kid, input logic apple, input logic goal);
    col          = c;
    row          = r;
    keys         = k;
    is_kid       = kid;
    is_apple_any = apple;
    is_goal      = goal;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // A frame of len cycles starting at (0,0); hit_at/goal_at give the cycle
  // index carrying that collision (-1 for none). Cycle 1 sits at (100,200).
  task automatic frame(input int len, input int hit_at, input int goal_at);
    for (int i = 0; i < len; i++) begin
      cyc((i == 0) ? 10'd0 : 10'(99 + i), (i == 0) ? 10'd0 : 10'd200, 4'd0,
          (i == hit_at) || (i == goal_at), i == hit_at, i == goal_at);
    end
  endtask

  task automatic press(input logic [3:0] k);
    cyc(10'd5, 10'd5, k, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic release_keys();
    cyc(10'd6, 10'd5, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] krand;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    col = '0; row = '0; keys = '0; is_kid = 0; is_apple_any = 0; is_goal = 0;
    model_reset();
    #1 rst = 1'b1;
    #2;
    check_eq("rst_state", {30'd0, state}, 0);
    check_eq("rst_freeze", {31'd0, freeze}, 1);
    check_eq("rst_deaths", {24'd0, death_count}, 0);
    cyc(10'd0, 10'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(10'd3, 10'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(10'd3, 10'd4, 4'd0, 1'b0, 1'b0, 1'b0);

    // Start from TITLE
    press(4'b0001);
    check_eq("start_state", {30'd0, state}, 1);
    check_eq("start_sprite", {31'd0, sprite_rst}, 1);
    check_eq("start_freeze", {31'd0, freeze}, 0);
    release_keys();
    check_eq("start_sprite_off", {31'd0, sprite_rst}, 0);

    // Apple hit mid-frame, death at next frame start
    frame(4, -1, -1);
    frame(4, 1, -1);
    cyc(10'd0, 10'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check_eq("hit_state", {30'd0, state}, 2);
    check_eq("hit_tick", {31'd0, frame_tick}, 1);
    check_eq("hit_deaths", {24'd0, death_count}, 1);
    check_eq("hit_freeze", {31'd0, freeze}, 1);
    for (int i = 0; i < 10; i++) frame(2, -1, -1);
    press(4'b1000);
    release_keys();
    check_eq("early_restart", {30'd0, state}, 2);
    for (int i = 0; i < 20; i++) frame(2, -1, -1);
    press(4'b1000);
    check_eq("restart_state", {30'd0, state}, 1);
    check_eq("restart_sprite", {31'd0, sprite_rst}, 1);
    check_eq("restart_deaths", {24'd0, death_count}, 1);
    release_keys();

    // Hit beats goal in the same frame
    frame(4, 1, 2);
    frame(4, -1, -1);
    check_eq("prio_state", {30'd0, state}, 2);
    for (int i = 0; i < DF; i++) frame(2, -1, -1);
    press(4'b1000);
    release_keys();
    frame(4, -1, 2);
    frame(4, -1, -1);
    check_eq("goal_state", {30'd0, state}, 3);
    check_eq("goal_deaths", {24'd0, death_count}, 2);
    press(4'b0010);
    check_eq("clear_to_title", {30'd0, state}, 0);
    release_keys();

    // Collision only in the (0,0) cycle counts for the new frame
    press(4'b0100);
    release_keys();
    frame(4, 0, -1);
    check_eq("edge_hit_wait", {30'd0, state}, 1);
    frame(4, -1, -1);
    check_eq("edge_hit_dead", {30'd0, state}, 2);

    // Randomized stimulus
    krand = 4'd0;
    for (int i = 0; i < 4000; i++) begin
      bit fs;
      fs = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) krand[$urandom_range(0, 3)] ^= 1'b1;
      cyc(fs ? 10'd0 : 10'($urandom_range(1, 1023)), fs ? 10'd0 : 10'($urandom_range(0, 1023)),
          krand, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 19) == 0);
    end

    // Reset with a key held through it: counts as a press on release
    rst = 1'b1;
    cyc(10'd7, 10'd7, 4'b0100, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(10'd8, 10'd7, 4'b0100, 1'b0, 1'b0, 1'b0);
    check_eq("held_key_start", {30'd0, state}, 1);
    release_keys();

    // Saturate the death counter
    for (int d = 0; d < 260; d++) begin
      frame(2, 1, -1);
      frame(2, -1, -1);
      if (d != 259) begin
        for (int i = 0; i < DF; i++) frame(2, -1, -1);
        press(4'b1000);
        release_keys();
      end
    end
    check_eq("sat_deaths", {24'd0, death_count}, 255);
    check_eq("sat_state", {30'd0, state}, 2);

    // Asynchronous reset mid-DEAD, checked before any clock edge
    frame(3, -1, -1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("async_state", {30'd0, state}, 0);
    check_eq("async_deaths", {24'd0, death_count}, 0);
    check_eq("async_freeze", {31'd0, freeze}, 1);
    cyc(10'd9, 10'd9, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(10'd9, 10'd9, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
